// File: rtl/mdu_pkg.sv
// Shared multiply/divide definitions: funct encodings and the MDU control states.
package mdu_pkg;

    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MTLO  = 6'b010011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic logic is_muldiv(input logic [5:0] f);
        return (f == FN_MULT) || (f == FN_MULTU) || (f == FN_DIV) || (f == FN_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Unsigned iterative datapath: shift-add multiply or restoring divide, one bit per step.
module muldiv_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_last
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    // Multiply: {partial product, multiplier}. Divide: low half holds dividend bits shifting into quotient.
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_b;
    logic [CNT_W-1:0]   r_cnt;

    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;

    always_comb begin
        w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : (WIDTH+1)'(0));
        w_shift   = {r_rem, r_acc[WIDTH-1]};
        w_diff    = w_shift - {1'b0, r_b};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_rem <= '0;
            r_b   <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_acc <= {WIDTH'(0), i_a};
            r_rem <= '0;
            r_b   <= i_b;
            r_cnt <= CNT_W'(WIDTH);
        end else if (i_step) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (i_is_div) begin
                // Restore when the trial subtract borrows; a zero divisor never borrows.
                if (!w_diff[WIDTH]) begin
                    r_rem              <= w_diff[WIDTH-1:0];
                    r_acc[WIDTH-1:0]   <= {r_acc[WIDTH-2:0], 1'b1};
                end else begin
                    r_rem              <= w_shift[WIDTH-1:0];
                    r_acc[WIDTH-1:0]   <= {r_acc[WIDTH-2:0], 1'b0};
                end
            end else begin
                r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
            end
        end
    end

    assign o_hi   = i_is_div ? r_rem : r_acc[2*WIDTH-1:WIDTH];
    assign o_lo   = r_acc[WIDTH-1:0];
    assign o_last = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/alu_muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
module alu_muldiv_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       ALU_control,
    input  logic [WIDTH-1:0] rs_content,
    input  logic [WIDTH-1:0] rt_content,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t             r_state;
    state_t             w_state_next;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_is_div;
    logic               r_neg_lo;
    logic               r_neg_hi;
    logic               r_div0;
    logic [WIDTH-1:0]   r_a_orig;

    logic               w_load;
    logic               w_step;
    logic               w_fix;
    logic               w_mthi;
    logic               w_mtlo;
    logic               w_signed;
    logic               w_is_div;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_raw_hi;
    logic [WIDTH-1:0]   w_raw_lo;
    logic               w_last;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    // Operand conditioning: signed ops feed magnitudes to the unsigned datapath.
    always_comb begin
        w_signed = (ALU_control == FN_MULT) || (ALU_control == FN_DIV);
        w_is_div = (ALU_control == FN_DIV) || (ALU_control == FN_DIVU);
        w_abs_a  = (w_signed && rs_content[WIDTH-1]) ? -rs_content : rs_content;
        w_abs_b  = (w_signed && rt_content[WIDTH-1]) ? -rt_content : rt_content;
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_is_div (r_is_div),
        .i_a      (w_abs_a),
        .i_b      (w_abs_b),
        .o_hi     (w_raw_hi),
        .o_lo     (w_raw_lo),
        .o_last   (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_fix        = 1'b0;
        w_mthi       = 1'b0;
        w_mtlo       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (is_muldiv(ALU_control)) begin
                        w_load       = 1'b1;
                        w_state_next = CALC;
                    end else if (ALU_control == FN_MTHI) begin
                        w_mthi = 1'b1;
                    end else if (ALU_control == FN_MTLO) begin
                        w_mtlo = 1'b1;
                    end
                end
            end
            CALC: begin
                w_step = 1'b1;
                if (w_last) w_state_next = FIX;
            end
            FIX: begin
                w_fix        = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Final sign correction; a zero divisor bypasses it and returns the original dividend.
    always_comb begin
        w_prod   = {w_raw_hi, w_raw_lo};
        w_fix_hi = w_raw_hi;
        w_fix_lo = w_raw_lo;
        if (r_is_div) begin
            if (r_div0) begin
                w_fix_lo = '1;
                w_fix_hi = r_a_orig;
            end else begin
                if (r_neg_lo) w_fix_lo = -w_raw_lo;
                if (r_neg_hi) w_fix_hi = -w_raw_hi;
            end
        end else if (r_neg_lo) begin
            w_prod   = -w_prod;
            w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
            w_fix_lo = w_prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_is_div <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_div0   <= 1'b0;
            r_a_orig <= '0;
        end else begin
            r_busy <= (w_state_next != IDLE);
            r_done <= w_fix;
            if (w_load) begin
                r_is_div <= w_is_div;
                r_neg_lo <= w_signed && (rs_content[WIDTH-1] ^ rt_content[WIDTH-1]);
                r_neg_hi <= w_signed && w_is_div && rs_content[WIDTH-1];
                r_div0   <= w_is_div && (rt_content == '0);
                r_a_orig <= rs_content;
            end
            if (w_fix) begin
                r_hi <= w_fix_hi;
                r_lo <= w_fix_lo;
            end
            if (w_mthi) r_hi <= rs_content;
            if (w_mtlo) r_lo <= rs_content;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Randomized and directed check of alu_muldiv_unit against a plain-arithmetic HI/LO model.
module tb_alu_muldiv_unit;
    import mdu_pkg::*;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [5:0]   alu_ctl;
    logic [W-1:0] rs;
    logic [W-1:0] rt;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;

    always #5 clk = ~clk;

    alu_muldiv_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .ALU_control (alu_ctl),
        .rs_content  (rs),
        .rt_content  (rt),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Architectural result of one instruction on the HI/LO pair.
    task automatic model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] p;
        longint      sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f)
            FN_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            FN_MULT: begin
                q = sa * sb;
                p = q;
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            FN_DIVU: begin
                if (b == 0) begin m_lo = '1; m_hi = a; end
                else begin m_lo = a / b; m_hi = a % b; end
            end
            FN_DIV: begin
                if (b == 0) begin m_lo = '1; m_hi = a; end
                else begin
                    q = sa / sb; r = sa % sb;
                    m_lo = q[31:0]; m_hi = r[31:0];
                end
            end
            FN_MTHI: m_hi = a;
            FN_MTLO: m_lo = a;
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit disturb, input string tag);
        int lat, busy_cnt;
        @(negedge clk);
        start = 1'b1; alu_ctl = f; rs = a; rt = b;
        @(posedge clk); #1;
        start = 1'b0; rs = $urandom; rt = $urandom; alu_ctl = 6'($urandom);
        model(f, a, b);
        if (!is_muldiv(f)) begin
            check({tag, "_busy"}, 64'(busy), 64'(0));
            check({tag, "_done"}, 64'(done), 64'(0));
            check({tag, "_hi"}, 64'(hi), 64'(m_hi));
            check({tag, "_lo"}, 64'(lo), 64'(m_lo));
            return;
        end
        lat = 0;
        busy_cnt = busy ? 1 : 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (done) begin lat = k; break; end
            if (busy) busy_cnt++;
            if (disturb && k == 5) begin start = 1'b1; alu_ctl = FN_MTLO; rs = 32'h1; end
            if (disturb && k == 8) start = 1'b0;
            rs = $urandom; rt = $urandom;
        end
        check({tag, "_latency"}, 64'(lat), 64'(W + 1));
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(W + 1));
        check({tag, "_hi"}, 64'(hi), 64'(m_hi));
        check({tag, "_lo"}, 64'(lo), 64'(m_lo));
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 64'(done), 64'(0));
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [5:0] fn_tab [8];
        fn_tab = '{FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_MTHI, FN_MTLO, 6'b100000, FN_DIV};
        rst = 1'b1; start = 1'b0; alu_ctl = '0; rs = '0; rt = '0;
        m_hi = '0; m_lo = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_hi", 64'(hi), 64'(0));
        check("reset_lo", 64'(lo), 64'(0));
        @(negedge clk); rst = 1'b0;

        run_op(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
        check("multu_max_hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFE);
        check("multu_max_lo_const", 64'(lo), 64'h0000_0000_0000_0001);
        run_op(FN_MULT, 32'hFFFF_FFFD, 32'h5, 1'b0, "mult_neg3x5");
        check("mult_neg3x5_lo_const", 64'(lo), 64'h0000_0000_FFFF_FFF1);
        run_op(FN_MULT, 32'd15, 32'd12, 1'b0, "mult_15x12");
        run_op(FN_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_neg7by2");
        check("div_neg7by2_hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFF);
        run_op(FN_DIVU, 32'd23, 32'd19, 1'b0, "divu_23by19");
        run_op(FN_DIVU, 32'h0000_000F, 32'h0, 1'b0, "divu_by0");
        run_op(FN_DIV, 32'hFFFF_FFF0, 32'h0, 1'b0, "div_neg_by0");
        run_op(FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_min_by_m1");
        check("div_min_by_m1_lo_const", 64'(lo), 64'h0000_0000_8000_0000);
        run_op(FN_MTHI, 32'h0000_000D, 32'h0, 1'b0, "mthi");
        run_op(6'b100000, 32'h1234_5678, 32'h1, 1'b0, "ignored_funct");
        run_op(FN_MULT, 32'd12, 32'd10, 1'b1, "mult_busy_start");
        check("mult_busy_start_lo_const", 64'(lo), 64'h0000_0000_0000_0078);

        // Reset in the middle of a divide.
        @(negedge clk);
        start = 1'b1; alu_ctl = FN_DIVU; rs = 32'd100; rt = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1; rst = 1'b1; #1;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        check("midrst_hi", 64'(hi), 64'(0));
        check("midrst_lo", 64'(lo), 64'(0));
        m_hi = '0; m_lo = '0;
        @(negedge clk); rst = 1'b0;
        run_op(FN_MULTU, 32'd2, 32'd3, 1'b0, "post_rst_multu");

        for (int i = 0; i < 40; i++) begin
            run_op(fn_tab[$urandom_range(0, 7)], pick_operand(), pick_operand(), 1'b0, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
